// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and the set-2 scan-code map for the PS/2
// keyboard interface.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {NORMAL, BRK, EXT, EXTBRK} kbd_state_t;

  localparam int STAT_NOT_EMPTY  = 7;
  localparam int STAT_OVERFLOW   = 6;
  localparam int STAT_PARITY_ERR = 5;
  localparam int STAT_FRAME_ERR  = 4;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_DROPS  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       isLetter;
    logic [7:0] ch;
  } key_map_t;

  // Letters come back uppercase; the caller applies case and ctrl.
  function automatic key_map_t f_mapScan(input logic [7:0] code, input logic shift);
    key_map_t m;
    m.valid    = 1'b1;
    m.isLetter = 1'b1;
    m.ch       = 8'h00;
    case (code)
      8'h1C: m.ch = "A";  8'h32: m.ch = "B";  8'h21: m.ch = "C";  8'h23: m.ch = "D";
      8'h24: m.ch = "E";  8'h2B: m.ch = "F";  8'h34: m.ch = "G";  8'h33: m.ch = "H";
      8'h43: m.ch = "I";  8'h3B: m.ch = "J";  8'h42: m.ch = "K";  8'h4B: m.ch = "L";
      8'h3A: m.ch = "M";  8'h31: m.ch = "N";  8'h44: m.ch = "O";  8'h4D: m.ch = "P";
      8'h15: m.ch = "Q";  8'h2D: m.ch = "R";  8'h1B: m.ch = "S";  8'h2C: m.ch = "T";
      8'h3C: m.ch = "U";  8'h2A: m.ch = "V";  8'h1D: m.ch = "W";  8'h22: m.ch = "X";
      8'h35: m.ch = "Y";  8'h1A: m.ch = "Z";
      default: begin
        m.isLetter = 1'b0;
        case (code)
          8'h45: m.ch = shift ? ")" : "0";
          8'h16: m.ch = shift ? "!" : "1";
          8'h1E: m.ch = shift ? "@" : "2";
          8'h26: m.ch = shift ? "#" : "3";
          8'h25: m.ch = shift ? "$" : "4";
          8'h2E: m.ch = shift ? "%" : "5";
          8'h36: m.ch = shift ? "^" : "6";
          8'h3D: m.ch = shift ? "&" : "7";
          8'h3E: m.ch = shift ? "*" : "8";
          8'h46: m.ch = shift ? "(" : "9";
          8'h0E: m.ch = shift ? "~" : 8'h60;
          8'h4E: m.ch = shift ? "_" : "-";
          8'h55: m.ch = shift ? "+" : "=";
          8'h54: m.ch = shift ? "{" : "[";
          8'h5B: m.ch = shift ? "}" : "]";
          8'h5D: m.ch = shift ? "|" : "\\";
          8'h4C: m.ch = shift ? ":" : ";";
          8'h52: m.ch = shift ? "\"" : "'";
          8'h41: m.ch = shift ? "<" : ",";
          8'h49: m.ch = shift ? ">" : ".";
          8'h4A: m.ch = shift ? "?" : "/";
          8'h66: m.ch = 8'h08;
          8'h5A: m.ch = 8'h0D;
          8'h29: m.ch = 8'h20;
          8'h76: m.ch = 8'h1B;
          default: m.valid = 1'b0;
        endcase
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo_rx_frame.sv
// PS/2 frame receiver: synchronises and glitch-filters key_clk in the system
// clock domain, shifts in 11-bit frames and flags framing/parity/timeout errors.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_keyClk,
  input  logic       i_keyDin,
  output logic       o_byteStb,
  output logic [7:0] o_byte,
  output logic       o_parityErrStb,
  output logic       o_frameErrStb
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    r_clkSync, r_dinSync;
  logic          r_filtClk, r_filtPrev;
  logic [7:0]    r_filtCnt;
  logic [9:0]    r_shift;
  logic [3:0]    r_bitCnt;
  logic [TW-1:0] r_toCnt;

  logic        w_fall;
  logic [10:0] w_frame;

  always_comb begin
    w_fall  = r_filtPrev & ~r_filtClk;
    w_frame = {r_dinSync[1], r_shift};
  end

  // Lines idle high, so synchronisers and the filtered clock reset to 1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clkSync      <= 2'b11;
      r_dinSync      <= 2'b11;
      r_filtClk      <= 1'b1;
      r_filtPrev     <= 1'b1;
      r_filtCnt      <= '0;
      r_shift        <= '0;
      r_bitCnt       <= '0;
      r_toCnt        <= '0;
      o_byteStb      <= 1'b0;
      o_byte         <= '0;
      o_parityErrStb <= 1'b0;
      o_frameErrStb  <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[0], i_keyClk};
      r_dinSync  <= {r_dinSync[0], i_keyDin};
      r_filtPrev <= r_filtClk;

      if (r_clkSync[1] == r_filtClk) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_MAX) begin
        r_filtClk <= r_clkSync[1];
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 8'd1;
      end

      o_byteStb      <= 1'b0;
      o_parityErrStb <= 1'b0;
      o_frameErrStb  <= 1'b0;

      // w_frame[0] is the start bit, [8:1] data, [9] parity, [10] stop.
      if (w_fall) begin
        r_toCnt <= '0;
        if (r_bitCnt == 4'(FRAME_BITS - 1)) begin
          r_bitCnt <= '0;
          if (w_frame[0] || !w_frame[10]) begin
            o_frameErrStb <= 1'b1;
          end else if ((^w_frame[9:1]) == 1'b0) begin
            o_parityErrStb <= 1'b1;
          end else begin
            o_byteStb <= 1'b1;
            o_byte    <= w_frame[8:1];
          end
        end else begin
          r_shift  <= w_frame[10:1];
          r_bitCnt <= r_bitCnt + 4'd1;
        end
      end else if (r_bitCnt != 4'd0) begin
        if (r_toCnt == TO_MAX) begin
          r_bitCnt      <= '0;
          r_toCnt       <= '0;
          o_frameErrStb <= 1'b1;
        end else begin
          r_toCnt <= r_toCnt + 1'b1;
        end
      end else begin
        r_toCnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// Apple-1 PS/2 keyboard interface: scan-code translator, character FIFO and
// the 4-register CPU read window.
module ps2_kbd_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_AW     = 3,
  parameter bit UPPER_ONLY  = 1'b1
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       key_clk,
  input  logic       key_din,
  input  logic       cs,
  input  logic [1:0] address,
  output logic [7:0] dout
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic       w_byteStb, w_parityErrStb, w_frameErrStb;
  logic [7:0] w_byte;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .i_clk         (clk25),
    .i_reset       (reset),
    .i_keyClk      (key_clk),
    .i_keyDin      (key_din),
    .o_byteStb     (w_byteStb),
    .o_byte        (w_byte),
    .o_parityErrStb(w_parityErrStb),
    .o_frameErrStb (w_frameErrStb)
  );

  kbd_state_t r_state;
  logic       r_shift, r_ctrl, r_caps;
  logic       r_emitStb;
  logic [7:0] r_emitChar;
  key_map_t   w_map;
  logic [7:0] w_char;

  always_comb begin
    w_map  = f_mapScan(w_byte, r_shift);
    w_char = w_map.ch;
    if (w_map.isLetter) begin
      if (r_ctrl)
        w_char = w_map.ch & 8'h1F;
      else if (!UPPER_ONLY && !(r_shift ^ r_caps))
        w_char = w_map.ch | 8'h20;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_state    <= NORMAL;
      r_shift    <= 1'b0;
      r_ctrl     <= 1'b0;
      r_caps     <= 1'b0;
      r_emitStb  <= 1'b0;
      r_emitChar <= '0;
    end else begin
      r_emitStb <= 1'b0;
      if (w_byteStb) begin
        case (r_state)
          NORMAL: begin
            if (w_byte == SC_BREAK)                               r_state <= BRK;
            else if (w_byte == SC_EXT)                            r_state <= EXT;
            else if (w_byte == SC_LSHIFT || w_byte == SC_RSHIFT)  r_shift <= 1'b1;
            else if (w_byte == SC_CTRL)                           r_ctrl  <= 1'b1;
            else if (w_byte == SC_CAPS)                           r_caps  <= ~r_caps;
            else if (w_map.valid) begin
              r_emitStb  <= 1'b1;
              r_emitChar <= w_char;
            end
          end
          BRK: begin
            if (w_byte == SC_LSHIFT || w_byte == SC_RSHIFT) r_shift <= 1'b0;
            if (w_byte == SC_CTRL)                          r_ctrl  <= 1'b0;
            r_state <= NORMAL;
          end
          EXT: begin
            if (w_byte == SC_BREAK) begin
              r_state <= EXTBRK;
            end else begin
              r_state <= NORMAL;
              if (w_byte == 8'h5A) begin
                r_emitStb  <= 1'b1;
                r_emitChar <= 8'h0D;
              end else if (w_byte == 8'h4A) begin
                r_emitStb  <= 1'b1;
                r_emitChar <= "/";
              end else if (w_byte == SC_CTRL) begin
                r_ctrl <= 1'b1;
              end
            end
          end
          EXTBRK: begin
            if (w_byte == SC_CTRL) r_ctrl <= 1'b0;
            r_state <= NORMAL;
          end
          default: r_state <= NORMAL;
        endcase
      end
    end
  end

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr, r_rdPtr;
  logic [FIFO_AW:0]   r_count;
  logic               r_csQ, r_overflow, r_parityErr, r_frameErr;
  logic [7:0]         r_raw, r_dropCnt;

  logic       w_rdEvent, w_empty, w_full, w_push, w_drop, w_pop, w_statusRd;
  logic [4:0] w_count5;
  logic [3:0] w_level;
  logic [7:0] w_status;

  always_comb begin
    w_rdEvent  = cs & ~r_csQ;
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_CNT);
    w_push     = r_emitStb & ~w_full;
    w_drop     = r_emitStb & w_full;
    w_pop      = w_rdEvent && (address == ADDR_DATA) && !w_empty;
    w_statusRd = w_rdEvent && (address == ADDR_STATUS);
    w_count5   = 5'(r_count);
    w_level    = w_count5[4] ? 4'hF : w_count5[3:0];
    w_status   = {4'h0, w_level};
    w_status[STAT_NOT_EMPTY]  = ~w_empty;
    w_status[STAT_OVERFLOW]   = r_overflow;
    w_status[STAT_PARITY_ERR] = r_parityErr;
    w_status[STAT_FRAME_ERR]  = r_frameErr;
  end

  always_ff @(posedge clk25) begin
    if (w_push) r_mem[r_wrPtr] <= r_emitChar;
  end

  // Sticky flags: a new error in the same cycle as a status read wins.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_csQ       <= 1'b0;
      r_overflow  <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_raw       <= '0;
      r_dropCnt   <= '0;
      dout        <= '0;
    end else begin
      r_csQ <= cs;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_drop)              r_overflow  <= 1'b1;
      else if (w_statusRd)     r_overflow  <= 1'b0;
      if (w_parityErrStb)      r_parityErr <= 1'b1;
      else if (w_statusRd)     r_parityErr <= 1'b0;
      if (w_frameErrStb)       r_frameErr  <= 1'b1;
      else if (w_statusRd)     r_frameErr  <= 1'b0;

      if (w_drop && r_dropCnt != 8'hFF) r_dropCnt <= r_dropCnt + 8'd1;
      if (w_byteStb)                    r_raw     <= w_byte;

      if (w_rdEvent) begin
        case (address)
          ADDR_DATA:   dout <= w_empty ? 8'h00 : r_mem[r_rdPtr];
          ADDR_STATUS: dout <= w_status;
          ADDR_RAW:    dout <= r_raw;
          default:     dout <= r_dropCnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: two instances (uppercase-only and case-following)
// share the PS/2 lines and are checked against a character-queue model.
module tb_ps2_kbd_fifo;

  localparam int TIMEOUT = 5000;
  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;
  localparam int HALF    = 20;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic       keyClk = 1'b1;
  logic       keyDin = 1'b1;
  logic       cs = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] doutUp, doutLo;

  int errors = 0;
  int checks = 0;

  logic [7:0] qUp[$], qLo[$];
  bit         mShift, mCtrl, mCaps, mBreak, mExt, mOverflow, mParityErr, mFrameErr;
  logic [7:0] mRaw, mDrops;
  logic [7:0] plainMap [int];
  logic [7:0] shiftMap [int];

  ps2_kbd_fifo #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT), .FIFO_AW(FIFO_AW), .UPPER_ONLY(1'b1)) dutUp (
    .clk25(clk25), .reset(reset), .key_clk(keyClk), .key_din(keyDin),
    .cs(cs), .address(address), .dout(doutUp));

  ps2_kbd_fifo #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT), .FIFO_AW(FIFO_AW), .UPPER_ONLY(1'b0)) dutLo (
    .clk25(clk25), .reset(reset), .key_clk(keyClk), .key_din(keyDin),
    .cs(cs), .address(address), .dout(doutLo));

  always #20 clk25 = ~clk25;

  initial begin
    #(40 * 150000);
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic addKey(input logic [7:0] code, input logic [7:0] plain, input logic [7:0] shifted);
    plainMap[int'(code)] = plain;
    shiftMap[int'(code)] = shifted;
  endtask

  task automatic modelReset();
    qUp.delete(); qLo.delete();
    {mShift, mCtrl, mCaps, mBreak, mExt, mOverflow, mParityErr, mFrameErr} = '0;
    mRaw = 8'h00; mDrops = 8'h00;
  endtask

  task automatic modelEmit(input logic [7:0] up, input logic [7:0] lo);
    if (qUp.size() < DEPTH) begin
      qUp.push_back(up);
      qLo.push_back(lo);
    end else begin
      mOverflow = 1'b1;
      if (mDrops != 8'hFF) mDrops = mDrops + 8'd1;
    end
  endtask

  // A key's meaning depends only on the pending prefix (break/extended) and the modifiers.
  task automatic modelByte(input logic [7:0] code);
    logic [7:0] plain, up, lo;
    mRaw = code;
    if (mBreak) begin
      if (!mExt && (code == 8'h12 || code == 8'h59)) mShift = 1'b0;
      if (code == 8'h14) mCtrl = 1'b0;
      mBreak = 1'b0; mExt = 1'b0;
    end else if (mExt) begin
      if (code == 8'hF0) mBreak = 1'b1;
      else begin
        if (code == 8'h5A) modelEmit(8'h0D, 8'h0D);
        else if (code == 8'h4A) modelEmit("/", "/");
        else if (code == 8'h14) mCtrl = 1'b1;
        mExt = 1'b0;
      end
    end else if (code == 8'hF0) mBreak = 1'b1;
    else if (code == 8'hE0) mExt = 1'b1;
    else if (code == 8'h12 || code == 8'h59) mShift = 1'b1;
    else if (code == 8'h14) mCtrl = 1'b1;
    else if (code == 8'h58) mCaps = !mCaps;
    else if (plainMap.exists(int'(code))) begin
      plain = plainMap[int'(code)];
      if (plain >= "a" && plain <= "z") begin
        up = plain - 8'd32;
        lo = (mShift ^ mCaps) ? up : plain;
        if (mCtrl) begin up = plain - 8'd96; lo = up; end
        modelEmit(up, lo);
      end else begin
        up = mShift ? shiftMap[int'(code)] : plain;
        modelEmit(up, up);
      end
    end
  endtask

  task automatic sendBits(input logic [7:0] code, input bit badParity, input int nBits, input int half);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ badParity, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk25);
      keyDin = bits[i];
      waitCycles(half);
      keyClk = 1'b0;
      waitCycles(half);
      keyClk = 1'b1;
    end
    keyDin = 1'b1;
    waitCycles(30);
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit badParity, input int half);
    sendBits(code, badParity, 11, half);
    if (badParity) mParityErr = 1'b1;
    else modelByte(code);
  endtask

  task automatic checkRead(input logic [1:0] addr, input int hold, input string tag);
    logic [7:0] expUp, expLo;
    int lvl;
    expUp = 8'h00;
    case (addr)
      2'd0: if (qUp.size() != 0) expUp = qUp.pop_front();
      2'd1: begin
        lvl = (qUp.size() > 15) ? 15 : qUp.size();
        expUp = {qUp.size() != 0, mOverflow, mParityErr, mFrameErr, 4'(lvl)};
        mOverflow = 1'b0; mParityErr = 1'b0; mFrameErr = 1'b0;
      end
      2'd2: expUp = mRaw;
      default: expUp = mDrops;
    endcase
    expLo = expUp;
    if (addr == 2'd0 && qLo.size() != 0 && qUp.size() + 1 == qLo.size()) expLo = qLo.pop_front();
    @(negedge clk25);
    address = addr;
    cs = 1'b1;
    waitCycles(hold);
    cs = 1'b0;
    checkOutput({tag, "/up"}, doutUp, expUp);
    checkOutput({tag, "/lo"}, doutLo, expLo);
    waitCycles(2);
  endtask

  task automatic typeKeys(input logic [7:0] codes[$]);
    foreach (codes[i]) applyStimulus(codes[i], 1'b0, HALF);
  endtask

  initial begin
    logic [7:0] pool[$];
    logic [7:0] code;
    int r;
    addKey(8'h1C, "a", "A"); addKey(8'h32, "b", "B"); addKey(8'h21, "c", "C");
    addKey(8'h23, "d", "D"); addKey(8'h24, "e", "E"); addKey(8'h2B, "f", "F");
    addKey(8'h34, "g", "G"); addKey(8'h33, "h", "H"); addKey(8'h43, "i", "I");
    addKey(8'h3B, "j", "J"); addKey(8'h16, "1", "!"); addKey(8'h1E, "2", "@");
    addKey(8'h4E, "-", "_"); addKey(8'h4A, "/", "?"); addKey(8'h29, 8'h20, 8'h20);
    addKey(8'h5A, 8'h0D, 8'h0D); addKey(8'h66, 8'h08, 8'h08); addKey(8'h76, 8'h1B, 8'h1B);
    modelReset();

    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("reset dout/up", doutUp, 8'h00);
    checkOutput("reset dout/lo", doutLo, 8'h00);
    for (int a = 0; a < 4; a++) checkRead(2'(a), 1, "reset reg");

    $display("[TB] slow frame 1C");
    applyStimulus(8'h1C, 1'b0, 1000);
    checkRead(2'd1, 1, "t1 status");
    checkRead(2'd0, 1, "t1 data");
    checkRead(2'd1, 1, "t1 status empty");
    checkRead(2'd2, 1, "t1 raw");

    $display("[TB] shifted digit");
    typeKeys('{8'h12, 8'h1E, 8'hF0, 8'h12, 8'h1E});
    checkRead(2'd1, 1, "t2 status");
    checkRead(2'd0, 1, "t2 at");
    checkRead(2'd0, 1, "t2 two");

    $display("[TB] caps, shift, ctrl");
    typeKeys('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C, 8'h14, 8'h21});
    checkRead(2'd0, 1, "t3 caps A");
    checkRead(2'd0, 1, "t3 shift a");
    checkRead(2'd0, 1, "t3 ctrl C");
    typeKeys('{8'hF0, 8'h12, 8'hF0, 8'h14, 8'h58, 8'hF0, 8'h58, 8'hE0, 8'h5A, 8'hE0, 8'h4A});
    checkRead(2'd0, 1, "t3 ext enter");
    checkRead(2'd0, 1, "t3 ext slash");

    $display("[TB] parity error and timeout");
    applyStimulus(8'h1C, 1'b1, HALF);
    checkRead(2'd1, 1, "t4 parity status");
    checkRead(2'd1, 1, "t4 parity reread");
    sendBits(8'h1C, 1'b0, 5, HALF);
    waitCycles(TIMEOUT + 200);
    mFrameErr = 1'b1;
    checkRead(2'd1, 1, "t4 timeout status");
    applyStimulus(8'h32, 1'b0, HALF);
    checkRead(2'd0, 1, "t4 after timeout");

    $display("[TB] reset mid-frame");
    sendBits(8'h24, 1'b0, 4, HALF);
    @(negedge clk25);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    modelReset();
    applyStimulus(8'h1C, 1'b0, HALF);
    checkRead(2'd1, 1, "reset mid status");
    checkRead(2'd0, 1, "reset mid data");

    $display("[TB] overflow");
    typeKeys('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B});
    checkRead(2'd1, 1, "t5 status full");
    checkRead(2'd3, 1, "t5 drops");
    for (int i = 0; i < DEPTH; i++) checkRead(2'd0, 1, "t5 drain");
    checkRead(2'd0, 1, "t5 empty read");

    $display("[TB] glitch and held cs");
    @(negedge clk25);
    keyClk = 1'b0;
    waitCycles(3);
    keyClk = 1'b1;
    waitCycles(40);
    typeKeys('{8'h1C, 8'h32});
    checkRead(2'd1, 1, "t6 status");
    checkRead(2'd0, 20, "t6 held pop");
    checkRead(2'd1, 1, "t6 level after hold");
    checkRead(2'd0, 1, "t6 second");

    $display("[TB] random keys");
    pool = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h4E, 8'h29, 8'h5A, 8'h4A, 8'h07,
             8'h12, 8'h59, 8'h14, 8'h58, 8'hF0, 8'hE0, 8'h66};
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        code = pool[$urandom_range(0, pool.size() - 1)];
        applyStimulus(code, $urandom_range(0, 9) == 0, HALF);
      end else begin
        checkRead(r < 8 ? 2'd0 : 2'($urandom_range(1, 3)), 1, "random read");
      end
    end
    checkRead(2'd1, 1, "random status");
    checkRead(2'd3, 1, "random drops");
    while (qUp.size() != 0) checkRead(2'd0, 1, "random drain");
    checkRead(2'd0, 1, "random empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
Second-generation PS/2 keyboard interface for the Apple-1 I/O page. It oversamples the PS/2 clock and data lines in the clk25 domain, so no logic is clocked by key_clk. It checks every frame (start, odd parity, stop, timeout) and translates scan-code set 2 to ASCII with shift, caps-lock and ctrl. Translated characters are queued in a parametrised FIFO, which the CPU reads through a 4-register window (data, status, last raw scan code, dropped-character count).

Parameters:
FILTER_LEN, 8, consecutive identical synchronised key_clk samples needed before the filtered clock changes state (legal range 2..255).
TIMEOUT_CYC, 50000, clk25 cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 25 MHz).
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (legal range 1..4).
UPPER_ONLY, 1, 1 = letters always uppercase (Apple-1 mode); 0 = letter case follows shift XOR caps-lock.

Ports:
clk25  in  1  25 MHz system clock; the only clock.
reset  in  1  synchronous, active-high reset.
key_clk  in  1  PS/2 clock from the keyboard; asynchronous.
key_din  in  1  PS/2 data from the keyboard; asynchronous.
cs  in  1  chip select, active high; may be held for many cycles.
address  in  2  register select: 0 data, 1 status, 2 raw scan code, 3 drop count.
dout  out  8  registered read data.

Behaviour:
- Reset (sampled on the clk25 edge) clears everything:
  - dout = 8'h00.
  - FIFO empty; pointers = 0.
  - Sticky flags = 0; drop count = 0; raw register = 0.
  - shift, ctrl, caps = 0; translator FSM in NORMAL; receiver idle with bit count = 0.
  - Reset mid-frame discards the partial frame.
- Synchronisation: key_clk and key_din each pass through a 2-FF synchroniser.
- Glitch filter: a counter on the synchronised key_clk updates the filtered clock after FILTER_LEN equal samples. A pulse shorter than FILTER_LEN cycles has no effect.
- Bit capture: on each filtered clock falling edge, capture synchronised key_din. Bits arrive LSB first: start, d0..d7, parity, stop (11 bits).
- On the 11th bit, exactly one of the following happens:
  - start=1 or stop=0: set FRAME_ERR; byte discarded.
  - Data XOR parity = 0 (odd-parity failure): set PARITY_ERR; byte discarded.
  - Otherwise: one-cycle byte strobe; raw register <= byte.
- Timeout: bit count nonzero and TIMEOUT_CYC cycles with no falling edge -> bit count = 0, set FRAME_ERR.
- Translator FSM states and transitions:
  - NORMAL: F0 -> BRK; E0 -> EXT; make code -> translate.
  - BRK: release code 12/59 clears shift; 14 clears ctrl; any code -> NORMAL.
  - EXT: F0 -> EXTBRK; 5A -> emit 8'h0D; 4A -> emit "/"; E0 14 sets ctrl; all others ignored; -> NORMAL.
  - EXTBRK: E0 F0 14 clears ctrl; -> NORMAL.
- Translation in NORMAL:
  - 12/59 set shift; 14 sets ctrl; 58 toggles caps. None of these emit a character.
  - Letters: uppercase if UPPER_ONLY, else uppercase when shift^caps; with ctrl held, emit letter & 8'h1F.
  - Digits and punctuation use the US shifted/unshifted map; 66 -> 8'h08; 5A -> 8'h0D; 29 -> 8'h20; 76 -> 8'h1B.
  - Unmapped codes emit nothing. Typematic repeats of make codes emit again.
- Emit latency: character is pushed 2 cycles after the byte strobe.
- FIFO:
  - Push when not full.
  - Push when full: character dropped, OVERFLOW set, drop count increments and saturates at 8'hFF.
- CPU interface:
  - A read event is the cs rising edge (cs & ~cs_q). dout updates on the next edge; a held cs produces exactly one event.
  - addr 0: dout = FIFO head, then pop. If empty, dout = 8'h00 and there is no pointer change.
  - addr 1: dout = {NOT_EMPTY, OVERFLOW, PARITY_ERR, FRAME_ERR, level[3:0]} using pre-event values. level saturates at 15. Bits 6:4 clear after the read; a simultaneous new error re-sets its flag (set wins).
  - addr 2: dout = raw register. addr 3: dout = drop count.
  - Push and pop in the same cycle: both occur and the level is unchanged. Push to an empty FIFO with a same-cycle pop: the pop returns 8'h00 and the push lands.
  - Outside read events dout holds its value.

Decomposition:
- Package ps2_pkg holds:
  - Scan constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_CAPS=58.
  - FSM state encoding (NORMAL, BRK, EXT, EXTBRK).
  - Status bit indices; register address constants.
- Sub-module ps2_rx_frame holds synchronisers, filter, shifter, frame/parity checks and timeout. It outputs byte_stb, byte[7:0], parity_err_stb, frame_err_stb.
- Translator, FIFO and CPU window live in the top level.

Test Plan:
1. Frame 1C at a 2000-cycle bit period, then cs on addr 1 -> 8'h81. Then addr 0 -> 8'h41; addr 1 -> 8'h00.
2. Frames 12,1E,F0,12,1E -> FIFO holds "@","2"; status level = 2.
3. UPPER_ONLY=0: 58,F0,58,1C,12,1C -> reads "A","a". Then 14,21 -> 8'h03.
4. Bad parity on 1C -> no character; status 8'h20, then 8'h00 on the re-read. A 5-bit partial frame then idle 50000 cycles -> FRAME_ERR set, and the next good frame decodes correctly.
5. FIFO_AW=3, 10 keys without reads -> level 8; OVERFLOW set; addr 3 = 8'h02; first read is the 1st key.
6. 3-cycle key_clk glitch with FILTER_LEN=8 -> no bit captured. cs held 20 cycles on addr 0 -> single pop.
